// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: states, opcodes,
// function codes, ALU operations, mux selects and the instruction classifier.
package mc_pkg;

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EXE_AL = 4'd2,
        S_EXE_BR = 4'd3,
        S_EXE_LS = 4'd4,
        S_MEM    = 4'd5,
        S_WB_AL  = 4'd6,
        S_WB_LD  = 4'd7,
        S_HALT   = 4'd8
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLTZ  = 6'b000001;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_JR  = 6'b001000;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_SLL  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_AND  = 3'b100,
        ALU_SLTU = 3'b101,
        ALU_SLT  = 3'b110,
        ALU_XOR  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        RD_31 = 2'b00,
        RD_RT = 2'b01,
        RD_RD = 2'b10
    } reg_dst_e;

    typedef enum logic [1:0] {
        PC_NEXT   = 2'b00,
        PC_BRANCH = 2'b01,
        PC_RS     = 2'b10,
        PC_JUMP   = 2'b11
    } pc_src_e;

    typedef enum logic [3:0] {
        C_RALU, C_IALU, C_BR, C_LS, C_J, C_JAL, C_JR, C_HALT, C_ILL
    } iclass_e;

    typedef struct packed {
        logic     pc_wre;
        logic     ir_wre;
        logic     ins_mem_rw;
        logic     alu_src_a;
        logic     alu_src_b;
        logic     ext_sel;
        alu_op_e  alu_op;
        logic     m_rd;
        logic     m_wr;
        logic     db_data_src;
        logic     reg_wre;
        logic     wr_reg_d_src;
        reg_dst_e reg_dst;
        pc_src_e  pc_src;
        logic     illegal;
        logic     halted;
    } ctl_t;

    function automatic iclass_e decode_class(input logic [5:0] op, input logic [5:0] funct);
        iclass_e c;
        c = C_ILL;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    F_ADD, F_SUB, F_AND, F_SLL, F_SLT: c = C_RALU;
                    F_JR:                              c = C_JR;
                    default:                           c = C_ILL;
                endcase
            end
            OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: c = C_IALU;
            OP_BEQ, OP_BNE, OP_BLTZ:                     c = C_BR;
            OP_LW, OP_SW:                                c = C_LS;
            OP_J:                                        c = C_J;
            OP_JAL:                                      c = C_JAL;
            OP_HALT:                                     c = C_HALT;
            default:                                     c = C_ILL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU operation decoder: maps op/funct to the ALU operation code.
// Latency: combinational, zero cycles. Backpressure: none, pure function of inputs.
// Unknown encodings fall back to ADD; the FSM flags them as illegal separately.
module mc_alu_dec
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output alu_op_e    alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    F_ADD:   alu_op = ALU_ADD;
                    F_SUB:   alu_op = ALU_SUB;
                    F_AND:   alu_op = ALU_AND;
                    F_SLL:   alu_op = ALU_SLL;
                    F_SLT:   alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            OP_ADDIU, OP_LW, OP_SW:  alu_op = ALU_ADD;
            OP_ANDI:                 alu_op = ALU_AND;
            OP_ORI:                  alu_op = ALU_OR;
            OP_XORI:                 alu_op = ALU_XOR;
            OP_SLTI:                 alu_op = ALU_SLT;
            OP_BEQ, OP_BNE, OP_BLTZ: alu_op = ALU_SUB;
            default:                 alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences IF/ID/EXE/MEM/WB and drives all datapath controls.
// Latency: Moore outputs per state; 2 to 5 cycles per instruction, PC written in the final state.
// Backpressure: none; op/funct must hold from ID to instruction end, halt exits only via rst.
module multicycle_ctrl
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       sign,
    output logic       PCWre,
    output logic       IRWre,
    output logic       InsMemRW,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic       ExtSel,
    output logic [2:0] ALUOp,
    output logic       mRD,
    output logic       mWR,
    output logic       DBDataSrc,
    output logic       RegWre,
    output logic       WrRegDSrc,
    output logic [1:0] RegDst,
    output logic [1:0] PCSrc,
    output logic       illegal,
    output logic       halted
);

    state_e  state, nxt;
    iclass_e cls;
    alu_op_e dec_op;
    ctl_t    c, o;
    logic    taken;

    mc_alu_dec u_alu_dec (
        .op     (op),
        .funct  (funct),
        .alu_op (dec_op)
    );

    assign cls = decode_class(op, funct);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IF;
        else      state <= nxt;
    end

    always_comb begin
        c     = '0;
        nxt   = state;
        taken = 1'b0;
        case (state)
            S_IF: begin
                c.ins_mem_rw = 1'b1;
                c.ir_wre     = 1'b1;
                nxt          = S_ID;
            end
            S_ID: begin
                case (cls)
                    C_RALU, C_IALU: nxt = S_EXE_AL;
                    C_BR:           nxt = S_EXE_BR;
                    C_LS:           nxt = S_EXE_LS;
                    C_J: begin
                        c.pc_src = PC_JUMP;
                        c.pc_wre = 1'b1;
                        nxt      = S_IF;
                    end
                    C_JAL: begin
                        c.pc_src       = PC_JUMP;
                        c.pc_wre       = 1'b1;
                        c.reg_wre      = 1'b1;
                        c.reg_dst      = RD_31;
                        c.wr_reg_d_src = 1'b0;
                        nxt            = S_IF;
                    end
                    C_JR: begin
                        c.pc_src = PC_RS;
                        c.pc_wre = 1'b1;
                        nxt      = S_IF;
                    end
                    C_HALT: nxt = S_HALT;
                    default: begin
                        // Unknown encodings retire as a nop so fetch keeps advancing.
                        c.illegal = 1'b1;
                        c.pc_wre  = 1'b1;
                        c.pc_src  = PC_NEXT;
                        nxt       = S_IF;
                    end
                endcase
            end
            S_EXE_AL: begin
                c.alu_src_a = (cls == C_RALU) && (funct == F_SLL);
                c.alu_src_b = (cls == C_IALU);
                c.ext_sel   = (op == OP_ADDIU) || (op == OP_SLTI);
                c.alu_op    = dec_op;
                nxt         = S_WB_AL;
            end
            S_WB_AL: begin
                c.reg_wre      = 1'b1;
                c.wr_reg_d_src = 1'b1;
                c.db_data_src  = 1'b0;
                c.reg_dst      = (cls == C_RALU) ? RD_RD : RD_RT;
                c.pc_wre       = 1'b1;
                nxt            = S_IF;
            end
            S_EXE_BR: begin
                case (op)
                    OP_BEQ:  taken = zero;
                    OP_BNE:  taken = ~zero;
                    OP_BLTZ: taken = sign;
                    default: taken = 1'b0;
                endcase
                c.alu_op  = ALU_SUB;
                c.ext_sel = 1'b1;
                c.pc_wre  = 1'b1;
                c.pc_src  = taken ? PC_BRANCH : PC_NEXT;
                nxt       = S_IF;
            end
            S_EXE_LS: begin
                c.alu_src_b = 1'b1;
                c.ext_sel   = 1'b1;
                c.alu_op    = ALU_ADD;
                nxt         = S_MEM;
            end
            S_MEM: begin
                if (op == OP_SW) begin
                    c.m_wr   = 1'b1;
                    c.pc_wre = 1'b1;
                    nxt      = S_IF;
                end else begin
                    c.m_rd = 1'b1;
                    nxt    = S_WB_LD;
                end
            end
            S_WB_LD: begin
                c.reg_wre      = 1'b1;
                c.reg_dst      = RD_RT;
                c.wr_reg_d_src = 1'b1;
                c.db_data_src  = 1'b1;
                c.pc_wre       = 1'b1;
                nxt            = S_IF;
            end
            S_HALT: begin
                c.halted = 1'b1;
                nxt      = S_HALT;
            end
            default: nxt = S_IF;
        endcase
    end

    // Reset masks every output combinationally so an aborted instruction writes nothing.
    assign o = rst ? '0 : c;

    assign PCWre     = o.pc_wre;
    assign IRWre     = o.ir_wre;
    assign InsMemRW  = o.ins_mem_rw;
    assign ALUSrcA   = o.alu_src_a;
    assign ALUSrcB   = o.alu_src_b;
    assign ExtSel    = o.ext_sel;
    assign ALUOp     = o.alu_op;
    assign mRD       = o.m_rd;
    assign mWR       = o.m_wr;
    assign DBDataSrc = o.db_data_src;
    assign RegWre    = o.reg_wre;
    assign WrRegDSrc = o.wr_reg_d_src;
    assign RegDst    = o.reg_dst;
    assign PCSrc     = o.pc_src;
    assign illegal   = o.illegal;
    assign halted    = o.halted;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl with hand-written halt and async-reset sequences.
module tb_multicycle_ctrl;

    logic       clk, rst;
    logic [5:0] op, funct;
    logic       zero, sign;
    logic       PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel;
    logic [2:0] ALUOp;
    logic       mRD, mWR, DBDataSrc, RegWre, WrRegDSrc;
    logic [1:0] RegDst, PCSrc;
    logic       illegal, halted;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .sign(sign),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .ALUOp(ALUOp), .mRD(mRD), .mWR(mWR),
        .DBDataSrc(DBDataSrc), .RegWre(RegWre), .WrRegDSrc(WrRegDSrc),
        .RegDst(RegDst), .PCSrc(PCSrc), .illegal(illegal), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [19:0] got;
    assign got = {PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel, ALUOp, mRD, mWR,
                  DBDataSrc, RegWre, WrRegDSrc, RegDst, PCSrc, illegal, halted};

    localparam logic [19:0] B_PCW = 20'h80000;
    localparam logic [19:0] B_IRW = 20'h40000;
    localparam logic [19:0] B_IMR = 20'h20000;
    localparam logic [19:0] B_ASA = 20'h10000;
    localparam logic [19:0] B_ASB = 20'h08000;
    localparam logic [19:0] B_EXT = 20'h04000;
    localparam logic [19:0] B_MRD = 20'h00400;
    localparam logic [19:0] B_MWR = 20'h00200;
    localparam logic [19:0] B_DBS = 20'h00100;
    localparam logic [19:0] B_RW  = 20'h00080;
    localparam logic [19:0] B_WRS = 20'h00040;
    localparam logic [19:0] B_ILL = 20'h00002;
    localparam logic [19:0] B_HLT = 20'h00001;
    localparam logic [19:0] IFV   = B_IRW | B_IMR;
    localparam logic [19:0] NONE  = 20'h00000;

    function automatic logic [19:0] alu(input logic [2:0] x);
        return {6'b0, x, 11'b0};
    endfunction
    function automatic logic [19:0] rd(input logic [1:0] x);
        return {14'b0, x, 4'b0};
    endfunction
    function automatic logic [19:0] pcs(input logic [1:0] x);
        return {16'b0, x, 2'b0};
    endfunction

    localparam logic [5:0] R0 = 6'b000000;

    typedef struct {
        string       name;
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic        sign;
        logic [19:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   nchk = 0;
    int   npass = 0;

    task automatic add(input string n, input logic r, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic s, input logic [19:0] e);
        vec_t v;
        v.name = n; v.rst = r; v.op = o; v.funct = f; v.zero = z; v.sign = s; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic chk(input string n, input logic [19:0] e);
        nchk++;
        if (got === e) npass++;
        else $display("FAIL %s: got %05h expected %05h", n, got, e);
    endtask

    task automatic drive(input logic r, input logic [5:0] o, input logic [5:0] f,
                         input logic z, input logic s);
        rst = r; op = o; funct = f; zero = z; sign = s;
    endtask

    initial begin
        drive(1'b1, R0, R0, 1'b0, 1'b0);

        add("reset",    1, R0, 6'h20, 0, 0, NONE);
        // add: IF ID EXE_AL WB_AL
        add("add.if",   0, R0, 6'h20, 0, 0, IFV);
        add("add.id",   0, R0, 6'h20, 0, 0, NONE);
        add("add.exe",  0, R0, 6'h20, 0, 0, alu(3'b000));
        add("add.wb",   0, R0, 6'h20, 0, 0, B_PCW | B_RW | B_WRS | rd(2'b10));
        add("sub.if",   0, R0, 6'h22, 0, 0, IFV);
        add("sub.id",   0, R0, 6'h22, 0, 0, NONE);
        add("sub.exe",  0, R0, 6'h22, 0, 0, alu(3'b001));
        add("sub.wb",   0, R0, 6'h22, 0, 0, B_PCW | B_RW | B_WRS | rd(2'b10));
        add("sll.if",   0, R0, 6'h00, 0, 0, IFV);
        add("sll.id",   0, R0, 6'h00, 0, 0, NONE);
        add("sll.exe",  0, R0, 6'h00, 0, 0, B_ASA | alu(3'b010));
        add("sll.wb",   0, R0, 6'h00, 0, 0, B_PCW | B_RW | B_WRS | rd(2'b10));
        add("ori.if",   0, 6'b001101, R0, 0, 0, IFV);
        add("ori.id",   0, 6'b001101, R0, 0, 0, NONE);
        add("ori.exe",  0, 6'b001101, R0, 0, 0, B_ASB | alu(3'b011));
        add("ori.wb",   0, 6'b001101, R0, 0, 0, B_PCW | B_RW | B_WRS | rd(2'b01));
        add("addiu.if", 0, 6'b001001, R0, 0, 0, IFV);
        add("addiu.id", 0, 6'b001001, R0, 0, 0, NONE);
        add("addiu.exe",0, 6'b001001, R0, 0, 0, B_ASB | B_EXT | alu(3'b000));
        add("addiu.wb", 0, 6'b001001, R0, 0, 0, B_PCW | B_RW | B_WRS | rd(2'b01));
        add("slti.if",  0, 6'b001010, R0, 0, 0, IFV);
        add("slti.id",  0, 6'b001010, R0, 0, 0, NONE);
        add("slti.exe", 0, 6'b001010, R0, 0, 0, B_ASB | B_EXT | alu(3'b110));
        add("slti.wb",  0, 6'b001010, R0, 0, 0, B_PCW | B_RW | B_WRS | rd(2'b01));
        add("andi.if",  0, 6'b001100, R0, 0, 0, IFV);
        add("andi.id",  0, 6'b001100, R0, 0, 0, NONE);
        add("andi.exe", 0, 6'b001100, R0, 0, 0, B_ASB | alu(3'b100));
        add("andi.wb",  0, 6'b001100, R0, 0, 0, B_PCW | B_RW | B_WRS | rd(2'b01));
        // lw: 5 cycles
        add("lw.if",    0, 6'b100011, R0, 0, 0, IFV);
        add("lw.id",    0, 6'b100011, R0, 0, 0, NONE);
        add("lw.exe",   0, 6'b100011, R0, 0, 0, B_ASB | B_EXT | alu(3'b000));
        add("lw.mem",   0, 6'b100011, R0, 0, 0, B_MRD);
        add("lw.wb",    0, 6'b100011, R0, 0, 0, B_PCW | B_RW | B_WRS | B_DBS | rd(2'b01));
        add("sw.if",    0, 6'b101011, R0, 0, 0, IFV);
        add("sw.id",    0, 6'b101011, R0, 0, 0, NONE);
        add("sw.exe",   0, 6'b101011, R0, 0, 0, B_ASB | B_EXT | alu(3'b000));
        add("sw.mem",   0, 6'b101011, R0, 0, 0, B_MWR | B_PCW);
        // branches: 3 cycles, taken/not-taken
        add("beq1.if",  0, 6'b000100, R0, 1, 0, IFV);
        add("beq1.id",  0, 6'b000100, R0, 1, 0, NONE);
        add("beq1.exe", 0, 6'b000100, R0, 1, 0, B_EXT | alu(3'b001) | B_PCW | pcs(2'b01));
        add("beq0.if",  0, 6'b000100, R0, 0, 0, IFV);
        add("beq0.id",  0, 6'b000100, R0, 0, 0, NONE);
        add("beq0.exe", 0, 6'b000100, R0, 0, 0, B_EXT | alu(3'b001) | B_PCW);
        add("bne0.if",  0, 6'b000101, R0, 0, 0, IFV);
        add("bne0.id",  0, 6'b000101, R0, 0, 0, NONE);
        add("bne0.exe", 0, 6'b000101, R0, 0, 0, B_EXT | alu(3'b001) | B_PCW | pcs(2'b01));
        add("bne1.if",  0, 6'b000101, R0, 1, 0, IFV);
        add("bne1.id",  0, 6'b000101, R0, 1, 0, NONE);
        add("bne1.exe", 0, 6'b000101, R0, 1, 0, B_EXT | alu(3'b001) | B_PCW);
        add("bltz1.if", 0, 6'b000001, R0, 0, 1, IFV);
        add("bltz1.id", 0, 6'b000001, R0, 0, 1, NONE);
        add("bltz1.exe",0, 6'b000001, R0, 0, 1, B_EXT | alu(3'b001) | B_PCW | pcs(2'b01));
        add("bltz0.if", 0, 6'b000001, R0, 1, 0, IFV);
        add("bltz0.id", 0, 6'b000001, R0, 1, 0, NONE);
        add("bltz0.exe",0, 6'b000001, R0, 1, 0, B_EXT | alu(3'b001) | B_PCW);
        // jumps: 2 cycles
        add("j.if",     0, 6'b000010, R0, 0, 0, IFV);
        add("j.id",     0, 6'b000010, R0, 0, 0, B_PCW | pcs(2'b11));
        add("jal.if",   0, 6'b000011, R0, 0, 0, IFV);
        add("jal.id",   0, 6'b000011, R0, 0, 0, B_PCW | B_RW | rd(2'b00) | pcs(2'b11));
        add("jr.if",    0, R0, 6'b001000, 0, 0, IFV);
        add("jr.id",    0, R0, 6'b001000, 0, 0, B_PCW | pcs(2'b10));
        add("ill.if",   0, 6'b010000, R0, 0, 0, IFV);
        add("ill.id",   0, 6'b010000, R0, 0, 0, B_ILL | B_PCW);
        add("illf.if",  0, R0, 6'b111111, 0, 0, IFV);
        add("illf.id",  0, R0, 6'b111111, 0, 0, B_ILL | B_PCW);
        // reset during sw MEM: no mWR, fetch restarts
        add("swr.if",   0, 6'b101011, R0, 0, 0, IFV);
        add("swr.id",   0, 6'b101011, R0, 0, 0, NONE);
        add("swr.exe",  0, 6'b101011, R0, 0, 0, B_ASB | B_EXT | alu(3'b000));
        add("swr.mem",  1, 6'b101011, R0, 0, 0, NONE);
        add("swr.if2",  0, 6'b101011, R0, 0, 0, IFV);
        add("swr.id2",  0, 6'b101011, R0, 0, 0, NONE);
        add("swr.exe2", 0, 6'b101011, R0, 0, 0, B_ASB | B_EXT | alu(3'b000));
        add("swr.mem2", 0, 6'b101011, R0, 0, 0, B_MWR | B_PCW);

        #1;
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].op, tbl[i].funct, tbl[i].zero, tbl[i].sign);
            #2;
            chk(tbl[i].name, tbl[i].exp);
            @(posedge clk); #1;
        end

        // halt: holds for 20 cycles, exits only through rst
        drive(1'b0, 6'b111111, R0, 1'b0, 1'b0);
        #2; chk("halt.if", IFV);
        @(posedge clk); #1;
        #2; chk("halt.id", NONE);
        @(posedge clk); #1;
        for (int k = 0; k < 20; k++) begin
            #2; chk($sformatf("halt.hold%0d", k), B_HLT);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #2; chk("halt.rst", NONE);
        @(posedge clk); #1;
        rst = 1'b0;
        #2; chk("halt.exit", IFV);

        // asynchronous reset pulse between clock edges during EXE_AL
        op = R0; funct = 6'h22;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2; chk("async.exe", alu(3'b001));
        rst = 1'b1;
        #1; chk("async.rst", NONE);
        rst = 1'b0;
        #1; chk("async.if", IFV);
        @(posedge clk); #1;
        #2; chk("async.id", NONE);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control-unit state machine for the 19-instruction multi-cycle MIPS CPU. It sequences the shared datapath (PC, instruction register, register file, single ALU, data memory) through fetch, decode, execute, memory and write-back states. It takes opcode/funct from the instruction register and zero/sign from the ALU, and drives every write enable and mux select. It sits inside `top` between the instruction register and the datapath muxes.

## Interface
- No parameters. State encoding, opcodes and ALU op codes come from the shared package.
- clk  in  1  system clock; all state changes occur on the rising edge.
- rst  in  1  reset. Asynchronous and active-high.
- op  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU result == 0.
- sign  in  1  ALU result[31].
- PCWre  out  1  PC write enable.
- IRWre  out  1  instruction register load.
- InsMemRW  out  1  instruction memory read.
- ALUSrcA  out  1  0 = rs data, 1 = shamt (zero-extended).
- ALUSrcB  out  1  0 = rt data, 1 = extended immediate.
- ExtSel  out  1  0 = zero-extend, 1 = sign-extend.
- ALUOp  out  3  ALU operation code.
- mRD  out  1  data memory read.
- mWR  out  1  data memory write.
- DBDataSrc  out  1  0 = ALU output register, 1 = memory data register.
- RegWre  out  1  register file write enable.
- WrRegDSrc  out  1  0 = PC+4 (jal), 1 = DataBus.
- RegDst  out  2  write register select: 00 = $31, 01 = rt, 10 = rd.
- PCSrc  out  2  next-PC select: 00 = PC+4, 01 = PC+4+(imm<<2), 10 = rs, 11 = jump target.
- illegal  out  1  one-cycle pulse in ID on an unknown op/funct.
- halted  out  1  high while the FSM is in S_HALT.

## Operation
- States: S_IF, S_ID, S_EXE_AL, S_EXE_BR, S_EXE_LS, S_MEM, S_WB_AL, S_WB_LD, S_HALT.
- Outputs are Moore-style. They are decoded combinationally from the state plus op/funct, with zero/sign used only in S_EXE_BR.
- Unlisted outputs are 0, and 0 is their default in every state.
- S_IF: InsMemRW=1, IRWre=1. Next state is S_ID.
- S_ID transitions by instruction:
  - R-ALU and I-ALU go to S_EXE_AL.
  - beq, bne and bltz go to S_EXE_BR.
  - lw and sw go to S_EXE_LS.
  - j: PCSrc=11, PCWre=1, then S_IF.
  - jal: additionally RegWre=1, RegDst=00, WrRegDSrc=0, then S_IF.
  - jr (R-type, funct 001000): PCSrc=10, PCWre=1, then S_IF.
  - halt (op 111111) goes to S_HALT.
  - Illegal encoding: illegal=1, PCWre=1, PCSrc=00, then S_IF (executes as a nop).
- S_EXE_AL: ALUSrcA=1 for sll only. ALUSrcB=1 for I-type. ExtSel=1 for addiu and slti. ALUOp is decoded from op/funct. Next state is S_WB_AL.
- S_WB_AL: RegWre=1, WrRegDSrc=1, DBDataSrc=0. RegDst=10 for R-type, 01 for I-type. PCWre=1. Next state is S_IF.
- S_EXE_BR: ALUOp=SUB, ExtSel=1, PCWre=1. PCSrc=01 when taken, otherwise 00. Next state is S_IF.
  - beq is taken when zero=1.
  - bne is taken when zero=0.
  - bltz is taken when sign=1; the datapath drives rs-$0.
- S_EXE_LS: ALUSrcB=1, ExtSel=1, ALUOp=ADD. Next state is S_MEM.
- S_MEM:
  - sw: mWR=1, PCWre=1, then S_IF.
  - lw: mRD=1, then S_WB_LD.
- S_WB_LD: RegWre=1, RegDst=01, WrRegDSrc=1, DBDataSrc=1, PCWre=1. Next state is S_IF.
- S_HALT: all enables are 0 and halted=1. The FSM leaves S_HALT only through rst.

## Timing
- Asynchronous reset puts the state in S_IF. While rst=1, every output is forced to 0, including IRWre and InsMemRW.
- The first fetch occurs in the first cycle after rst deasserts.
- Reset asserted mid-instruction aborts that instruction immediately. No write enable is asserted after the rst edge.
- PCWre is asserted exactly once per instruction, in that instruction's final state. The PC therefore updates on the edge that returns the FSM to S_IF.
- Cycles per instruction:
  - ALU: 4.
  - lw: 5.
  - sw: 4.
  - Branch: 3.
  - j, jal, jr: 2.
  - Illegal: 2.
- RegWre and mWR are never high in the same cycle. RegWre and PCWre coincide only in S_WB_AL, S_WB_LD and for jal.
- op and funct must be stable from S_ID until the instruction ends; IRWre is high only in S_IF.

## Structure
- Package `mc_pkg` holds:
  - the state enum (4-bit);
  - opcode constants for the 19 instructions: add, sub, addiu, and, andi, ori, xori, sll, slt, slti, sw, lw, beq, bne, bltz, j, jal, jr, halt;
  - funct constants;
  - ALUOp codes: ADD=000, SUB=001, SLL=010, OR=011, AND=100, SLTU=101, SLT=110, XOR=111;
  - RegDst and PCSrc codes.
- One natural sub-module, `mc_alu_dec`: op/funct to ALUOp, purely combinational. It is shared with the datapath assertions. The FSM and output decode stay in `multicycle_ctrl`.

## Test plan
- Reset then add (op 000000, funct 100000): state sequence IF, ID, EXE_AL, WB_AL, IF. RegWre=1 and RegDst=10 only in WB_AL. PCWre=1 only in WB_AL.
- lw (op 100011): 5 cycles. mRD=1 in MEM. DBDataSrc=1, RegDst=01 and RegWre=1 in WB_LD.
- sw (op 101011): mWR=1 for exactly one cycle. RegWre=0 throughout.
- beq with zero=1 gives PCSrc=01; with zero=0 gives PCSrc=00. bltz with sign=1 gives PCSrc=01. All three take 3 cycles.
- jal (op 000011): 2 cycles. In ID: RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11. jr: PCSrc=10.
- Cross-state checks:
  - op=111111 enters S_HALT and holds halted=1 for 20 cycles.
  - rst pulse returns the FSM to S_IF.
  - rst asserted during S_MEM of sw means mWR never rises.
  - Unknown op 010000 pulses illegal=1 and gives PCWre=1.
